// File: rtl/divn_iter.sv
`default_nettype none
// ============================================================================
//  Module      : divn_iter
//  Description : Iterative restoring radix-2 divider, WIDTH-bit operands,
//                STEPS quotient bits per clock, signed/unsigned per operation,
//                divide-by-zero flag, start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module divn_iter #(
  parameter int WIDTH = 64,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - STEPS);
  localparam logic [CW-1:0] c_step = CW'(STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_a_raw;
  logic [CW-1:0]      r_count;
  logic               r_a_neg;
  logic               r_q_neg;
  logic               r_err_pending;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH:0]     w_partial;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;

  // Operand signs only matter in signed mode; magnitudes feed the unsigned core.
  assign w_a_neg  = sel & a[WIDTH-1];
  assign w_b_neg  = sel & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);
  assign w_q_mag  = r_acc[WIDTH-1:0];
  assign w_r_mag  = r_acc[2*WIDTH-1:WIDTH];

  // STEPS restoring sub-iterations per clock. The bit shifted out of the top
  // of the accumulator is kept in w_partial[WIDTH] so that a partial
  // remainder larger than 2^WIDTH-1 still compares correctly.
  always_comb begin
    w_acc_next = r_acc;
    w_partial  = '0;
    for (int i = 0; i < STEPS; i++) begin
      w_partial = w_acc_next[2*WIDTH-1:WIDTH-1];
      if (w_partial >= {1'b0, r_div}) begin
        w_partial  = w_partial - {1'b0, r_div};
        w_acc_next = {w_partial[WIDTH-1:0], w_acc_next[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_next = {w_acc_next[2*WIDTH-2:0], 1'b0};
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a zero divisor skips the iteration phase entirely.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = w_b_zero ? S_FIX : S_CALC;
      S_CALC: if (r_count == c_last) w_state_next = S_FIX;
      S_FIX:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; results only change in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_div         <= '0;
      r_a_raw       <= '0;
      r_count       <= '0;
      r_a_neg       <= 1'b0;
      r_q_neg       <= 1'b0;
      r_err_pending <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      quotient      <= '0;
      remainder     <= '0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc         <= {{WIDTH{1'b0}}, w_a_mag};
            r_div         <= w_b_mag;
            r_a_raw       <= a;
            r_a_neg       <= w_a_neg;
            r_q_neg       <= w_a_neg ^ w_b_neg;
            r_err_pending <= w_b_zero;
            r_count       <= '0;
          end
        end
        S_CALC: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + c_step;
        end
        S_FIX: begin
          if (r_err_pending) begin
            quotient  <= '1;
            remainder <= r_a_raw;
          end else begin
            quotient  <= r_q_neg ? (~w_q_mag + 1'b1) : w_q_mag;
            remainder <= r_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;
          end
          err  <= r_err_pending;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
